// File: rtl/ext_irq_responder.sv
// ext_irq_responder: memory-mapped external interrupt source with
// programmable period/mode and an ACK-driven pending-request counter.
module ext_irq_responder #(
    parameter logic [31:0] BASE   = 32'h0000_7F20,
    parameter int          PEND_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_FIRE = 2'd3;

    localparam logic [1:0] OFF_ACK    = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_PERIOD = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [1:0]        state;
    logic              en;
    logic              mode;
    logic [31:0]       period;
    logic [31:0]       count;
    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] pending_nxt;

    logic       sel;
    logic       wr;
    logic [1:0] off;
    logic       ack;
    logic       fire;

    assign sel  = (addr[31:4] == BASE[31:4]);
    assign off  = addr[3:2];
    assign wr   = sel && (byteen != 4'b0000);
    assign ack  = wr && (off == OFF_ACK);
    assign fire = (state == S_FIRE);

    // Next pending count: fire adds, ack retires, both together cancel out.
    always_comb begin
        pending_nxt = pending;
        if (fire && !ack) begin
            if (pending != PEND_MAX)
                pending_nxt = pending + 1'b1;
        end else if (ack && !fire) begin
            if (pending != '0)
                pending_nxt = pending - 1'b1;
        end
    end

    // Sequencer plus CTRL register; a software CTRL write overrides the
    // one-shot auto-disable when both land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            en    <= 1'b0;
            mode  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && (period != '0))
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    count <= period;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!en)
                        state <= S_IDLE;
                    else if (count > 32'd1)
                        count <= count - 32'd1;
                    else
                        state <= S_FIRE;
                end
                default: begin
                    if (mode && en) begin
                        state <= S_LOAD;
                    end else begin
                        en    <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase
            if (wr && (off == OFF_CTRL) && byteen[0]) begin
                en   <= wdata[0];
                mode <= wdata[1];
            end
        end
    end

    // PERIOD register with per-byte write enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            period <= '0;
        end else if (wr && (off == OFF_PERIOD)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteen[b])
                    period[8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Pending counter and the registered interrupt line.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            irq     <= (pending_nxt != '0);
        end
    end

    // Combinational read mux; anything outside the window reads zero.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_CTRL:   rdata = {30'd0, mode, en};
                OFF_PERIOD: rdata = period;
                OFF_STATUS: begin
                    rdata[PEND_W-1:0] = pending;
                    rdata[31]         = irq;
                end
                default:    rdata = '0;
            endcase
        end
    end

endmodule
